truth_table_scanner: RTL and testbench

// - Sequential, parametrised successor to the fixed 3-input boolean expression blocks.
// - On start, sweeps every input combination 0..2^N-1 and evaluates a selectable function over masked inputs.
// - Streams each truth-table row over a valid/ready handshake.
// - Accumulates a minterm bitmap and a ones count; both are read when done pulses.
// - Sits between the stimulus/self-check logic and any row consumer (display or monitor model).

---
 rtl/truth_table_scanner_pkg.sv | 17 +
 rtl/truth_table_scanner_if.sv | 16 +
 rtl/truth_table_scanner_tt_eval.sv | 33 +++
 rtl/truth_table_scanner.sv | 88 ++++++++
 tb/tb_truth_table_scanner.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner.
//   MODE_* : 2-bit function-select codes driven on the scanner's mode port
//   state_e: scanner FSM state encoding
package truth_table_scanner_pkg;

  localparam logic [1:0] MODE_XOR  = 2'd0;
  localparam logic [1:0] MODE_XNOR = 2'd1;
  localparam logic [1:0] MODE_AND  = 2'd2;
  localparam logic [1:0] MODE_OR   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/truth_table_scanner_if.sv
// Row stream carried from the scanner to a row consumer.
//   row_valid : row_in/row_s hold a valid row        (master -> slave)
//   row_ready : consumer accepts the row              (slave -> master)
//   row_in    : input combination (row index), N bits (master -> slave)
//   row_s     : function value for row_in             (master -> slave)
interface truth_table_scanner_if #(parameter int N = 3);

  logic         row_valid;
  logic         row_ready;
  logic [N-1:0] row_in;
  logic         row_s;

  modport master (output row_valid, row_in, row_s, input row_ready);
  modport slave  (input row_valid, row_in, row_s, output row_ready);

endinterface

// File: rtl/truth_table_scanner_tt_eval.sv
// tt_eval: combinational boolean function over the masked inputs.
//   vec  : input combination, bit N-1 is the MSB
//   mask : bit i = 1 includes vec[i] in the function
//   mode : MODE_XOR / MODE_XNOR / MODE_AND / MODE_OR
//   s    : function value
// An empty mask gives XOR=0, XNOR=1, AND=1 (empty product), OR=0.
module tt_eval
  import truth_table_scanner_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] vec,
  input  logic [N-1:0] mask,
  input  logic [1:0]   mode,
  output logic         s
);

  logic [N-1:0] sel;
  assign sel = vec & mask;

  always_comb begin
    s = 1'b0;
    case (mode)
      MODE_XOR:  s = ^sel;
      MODE_XNOR: s = ~^sel;
      // Unselected inputs are forced to 1 so they drop out of the product.
      MODE_AND:  s = &(vec | ~mask);
      MODE_OR:   s = |sel;
      default:   s = 1'b0;
    endcase
  end

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: on start, walks rows 0..2^N-1, evaluates the selected
// function over the masked inputs and streams each row over valid/ready.
// A minterm bitmap and ones count are built up and are valid from done.
//   clk, reset      : clock, synchronous active-high reset
//   start           : begin a sweep (only looked at in IDLE)
//   mode, mask      : function select and input mask, latched at start
//   busy, done      : high in RUN / one-cycle pulse at sweep end
//   row             : row stream (master side)
//   minterms        : bit i = f(i)
//   ones_cnt        : number of rows with f = 1, 0..ROWS
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter  int N    = 3,
  localparam int ROWS = 1 << N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [N-1:0]           mask,
  output logic                   busy,
  output logic                   done,
  truth_table_scanner_if.master  row,
  output logic [ROWS-1:0]        minterms,
  output logic [N:0]             ones_cnt
);

  localparam logic [N-1:0] LAST = '1;

  state_e       state, state_nxt;
  logic [N-1:0] cnt;
  logic [1:0]   mode_q;
  logic [N-1:0] mask_q;
  logic         f;
  logic         fire;

  tt_eval #(.N(N)) u_eval (
    .vec  (cnt),
    .mask (mask_q),
    .mode (mode_q),
    .s    (f)
  );

  assign busy          = (state == ST_RUN);
  assign done          = (state == ST_DONE);
  assign row.row_valid = busy;
  assign row.row_in    = cnt;
  // Gate with busy so a stale value from the last row never leaks out in IDLE.
  assign row.row_s     = busy & f;
  assign fire          = busy & row.row_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (fire && cnt == LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mode_q   <= '0;
      mask_q   <= '0;
      minterms <= '0;
      ones_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        mode_q   <= mode;
        mask_q   <= mask;
        cnt      <= '0;
        minterms <= '0;
        ones_cnt <= '0;
      end else if (fire) begin
        minterms[cnt] <= f;
        ones_cnt      <= ones_cnt + {{N{1'b0}}, f};
        // Counter parks on the last row rather than wrapping.
        if (cnt != LAST) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // N=3 instance
  logic       start3, busy3, done3;
  logic [1:0] mode3;
  logic [2:0] mask3;
  logic [7:0] min3;
  logic [3:0] ones3;
  truth_table_scanner_if #(.N(3)) rif3 ();

  truth_table_scanner #(.N(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .mode(mode3), .mask(mask3),
    .busy(busy3), .done(done3), .row(rif3.master),
    .minterms(min3), .ones_cnt(ones3)
  );

  // N=5 instance
  logic        start5, busy5, done5;
  logic [1:0]  mode5;
  logic [4:0]  mask5;
  logic [31:0] min5;
  logic [5:0]  ones5;
  truth_table_scanner_if #(.N(5)) rif5 ();

  truth_table_scanner #(.N(5)) u_dut5 (
    .clk(clk), .reset(reset), .start(start5), .mode(mode5), .mask(mask5),
    .busy(busy5), .done(done5), .row(rif5.master),
    .minterms(min5), .ones_cnt(ones5)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int idx; logic s; } row_t;
  row_t q3[$];
  row_t q5[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: count selected inputs and how many of them are 1.
  function automatic logic ref_f(input int n, input logic [1:0] m,
                                 input logic [5:0] mk, input int v);
    int sel = 0;
    int on  = 0;
    for (int i = 0; i < n; i++)
      if (mk[i]) begin
        sel++;
        if (v[i]) on++;
      end
    case (m)
      2'd0:    return (on % 2) == 1;
      2'd1:    return (on % 2) == 0;
      2'd2:    return on == sel;
      default: return on > 0;
    endcase
  endfunction

  task automatic sweep3(input logic [1:0] m, input logic [2:0] mk,
                        input int stall_at, input int stall_len, input bit midchange,
                        output logic [7:0] got_min, output logic [3:0] got_ones);
    logic [7:0] emin = '0;
    int eones = 0;
    int cyc = 0;
    int stalls = 0;
    bit seen = 0;
    row_t r;
    for (int i = 0; i < 8; i++) begin
      r.idx = i; r.s = ref_f(3, m, {3'b0, mk}, i);
      q3.push_back(r);
      emin[i] = r.s;
      eones += int'(r.s);
    end
    @(negedge clk);
    start3 = 1'b1; mode3 = m; mask3 = mk; rif3.row_ready = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    while (cyc < 200) begin
      @(negedge clk); cyc++;
      if (done3) begin seen = 1; break; end
      start3 = 1'b0;
      if (rif3.row_valid) begin
        if (int'(rif3.row_in) == stall_at && stalls < stall_len) begin
          rif3.row_ready = 1'b0;
          if (stalls > 0) begin
            chk("hold_row_in", 64'(rif3.row_in), 64'(stall_at));
            chk("hold_row_s", 64'(rif3.row_s), 64'(ref_f(3, m, {3'b0, mk}, stall_at)));
          end
          stalls++;
        end else begin
          rif3.row_ready = 1'b1;
          if (midchange && rif3.row_in == 3'd3) begin
            start3 = 1'b1; mask3 = ~mk; mode3 = m + 2'd1;
          end
          if (q3.size() == 0) chk("extra_row", 64'(rif3.row_in), 64'hFF);
          else begin
            r = q3.pop_front();
            chk("row_in", 64'(rif3.row_in), 64'(r.idx));
            chk("row_s", 64'(rif3.row_s), 64'(r.s));
          end
        end
      end
    end
    start3 = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("done_latency", 64'(cyc), 64'(9 + stall_len));
    chk("done_busy", 64'(busy3), 64'd0);
    chk("done_valid", 64'(rif3.row_valid), 64'd0);
    chk("rows_left", 64'(q3.size()), 64'd0);
    chk("minterms3", 64'(min3), 64'(emin));
    chk("ones3", 64'(ones3), 64'(eones));
    got_min = min3; got_ones = ones3;
    @(negedge clk);
    chk("done_pulse", 64'(done3), 64'd0);
    chk("min3_hold", 64'(min3), 64'(emin));
    q3.delete();
  endtask

  task automatic sweep5(input logic [1:0] m, input logic [4:0] mk);
    logic [31:0] emin = '0;
    int eones = 0;
    int cyc = 0;
    bit seen = 0;
    row_t r;
    for (int i = 0; i < 32; i++) begin
      r.idx = i; r.s = ref_f(5, m, {1'b0, mk}, i);
      q5.push_back(r);
      emin[i] = r.s;
      eones += int'(r.s);
    end
    @(negedge clk);
    start5 = 1'b1; mode5 = m; mask5 = mk;
    @(posedge clk); #1 start5 = 1'b0;
    while (cyc < 400) begin
      @(negedge clk); cyc++;
      if (done5) begin seen = 1; break; end
      start5 = 1'b0;
      rif5.row_ready = 1'($urandom_range(3, 0) != 0);
      if (rif5.row_valid && rif5.row_ready) begin
        if (rif5.row_in == 5'd10) begin
          start5 = 1'b1; mask5 = ~mk; mode5 = ~m;
        end
        if (q5.size() == 0) chk("extra_row5", 64'(rif5.row_in), 64'hFF);
        else begin
          r = q5.pop_front();
          chk("row5_in", 64'(rif5.row_in), 64'(r.idx));
          chk("row5_s", 64'(rif5.row_s), 64'(r.s));
        end
      end
    end
    start5 = 1'b0;
    chk("done5_seen", 64'(seen), 64'd1);
    chk("rows5_left", 64'(q5.size()), 64'd0);
    chk("minterms5", 64'(min5), 64'(emin));
    chk("ones5", 64'(ones5), 64'(eones));
    q5.delete();
  endtask

  logic [7:0] gm;
  logic [3:0] go;

  initial begin
    reset = 1'b1;
    start3 = 0; mode3 = 0; mask3 = 0; rif3.row_ready = 0;
    start5 = 0; mode5 = 0; mask5 = 0; rif5.row_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy3), 64'd0);
    chk("rst_done", 64'(done3), 64'd0);
    chk("rst_valid", 64'(rif3.row_valid), 64'd0);
    chk("rst_row_in", 64'(rif3.row_in), 64'd0);
    chk("rst_row_s", 64'(rif3.row_s), 64'd0);
    chk("rst_min", 64'(min3), 64'd0);
    chk("rst_ones", 64'(ones3), 64'd0);
    reset = 1'b0;

    // Test 1: XOR over y,z
    sweep3(2'd0, 3'b011, -1, 0, 0, gm, go);
    chk("t1_min", 64'(gm), 64'h66);
    chk("t1_ones", 64'(go), 64'd4);

    // Test 2: AND / OR of all inputs
    sweep3(2'd2, 3'b111, -1, 0, 0, gm, go);
    chk("t2_and_min", 64'(gm), 64'h80);
    chk("t2_and_ones", 64'(go), 64'd1);
    sweep3(2'd3, 3'b111, -1, 0, 0, gm, go);
    chk("t2_or_min", 64'(gm), 64'hFE);
    chk("t2_or_ones", 64'(go), 64'd7);

    // Test 3: XNOR with empty mask -> every row is 1
    sweep3(2'd1, 3'b000, -1, 0, 0, gm, go);
    chk("t3_min", 64'(gm), 64'hFF);
    chk("t3_ones", 64'(go), 64'd8);

    // Test 4: three stalled cycles at row 2
    sweep3(2'd0, 3'b011, 2, 3, 0, gm, go);
    chk("t4_min", 64'(gm), 64'h66);
    chk("t4_ones", 64'(go), 64'd4);

    // Test 5: reset at row 4 mid-sweep
    @(negedge clk);
    start3 = 1'b1; mode3 = 2'd0; mask3 = 3'b011; rif3.row_ready = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rif3.row_in == 3'd4) break;
    end
    chk("t5_at_row4", 64'(rif3.row_in), 64'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_busy", 64'(busy3), 64'd0);
    chk("t5_valid", 64'(rif3.row_valid), 64'd0);
    chk("t5_done", 64'(done3), 64'd0);
    chk("t5_min", 64'(min3), 64'd0);
    chk("t5_ones", 64'(ones3), 64'd0);
    chk("t5_row_in", 64'(rif3.row_in), 64'd0);
    reset = 1'b0;
    sweep3(2'd0, 3'b011, -1, 0, 0, gm, go);
    chk("t5_fresh_min", 64'(gm), 64'h66);

    // Test 6: start pulse and mask/mode change mid-sweep are ignored
    sweep3(2'd0, 3'b101, -1, 0, 1, gm, go);
    chk("t6_min", 64'(gm), 64'h5A);
    chk("t6_ones", 64'(go), 64'd4);
    sweep5(2'd0, 5'b10110);
    sweep5(2'd2, 5'b01011);
    sweep5(2'd3, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
